// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared constants, channel state encoding and helpers for the
//               programmable clock-divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkdiv_pkg;

    localparam int c_cnt_w       = 16;
    localparam int c_default_div = 500;

    // Write response codes, bit 0 = ack, bit 1 = err
    localparam logic [1:0] c_resp_none = 2'b00;
    localparam logic [1:0] c_resp_ack  = 2'b01;
    localparam logic [1:0] c_resp_err  = 2'b10;

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_RUN_PEND = 2'd2
    } chan_state_e;

    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_chan.sv
// ============================================================================
// Module      : clkdiv_chan
// Description : One divider channel: counter, active and pending divisor,
//               square-wave output and toggle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w,
    parameter int DEFAULT_DIV = c_default_div
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [CNT_W-1:0] c_div_rst = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_clk_div;
    logic             r_tick;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             w_pend_valid_nxt;
    logic             w_clk_div_nxt;
    logic             w_tick_nxt;
    logic             w_term;
    chan_state_e      w_state;

    // >= rather than == so a divisor shrunk while stopped can never wrap
    assign w_term = (r_cnt >= (r_div - c_one));

    always_comb begin
        w_state = ST_RUN;
        if (!en) begin
            w_state = ST_STOP;
        end else if (r_pend_valid) begin
            w_state = ST_RUN_PEND;
        end
    end

    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_div_nxt        = r_div;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_clk_div_nxt    = r_clk_div;
        w_tick_nxt       = 1'b0;
        case (w_state)
            ST_STOP: begin
                if (r_pend_valid) begin
                    w_div_nxt        = r_pend;
                    w_pend_valid_nxt = 1'b0;
                end
            end
            ST_RUN, ST_RUN_PEND: begin
                if (w_term) begin
                    w_cnt_nxt     = '0;
                    w_clk_div_nxt = ~r_clk_div;
                    w_tick_nxt    = 1'b1;
                    if (w_state == ST_RUN_PEND) begin
                        w_div_nxt        = r_pend;
                        w_pend_valid_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            default: begin
            end
        endcase
        // A write landing on a terminal count waits for the next one
        if (ld) begin
            w_pend_nxt       = ld_val;
            w_pend_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_div        <= c_div_rst;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_clk_div    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_div        <= w_div_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_clk_div    <= w_clk_div_nxt;
            r_tick       <= w_tick_nxt;
        end
    end

    assign clk_div = r_clk_div;
    assign tick    = r_tick;

endmodule

`default_nettype wire

// File: rtl/clkdiv_bank.sv
// ============================================================================
// Module      : clkdiv_bank
// Description : Bank of NUM_CH runtime-programmable clock dividers with
//               validated divisor writes and one-cycle ack/err responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = c_cnt_w,
    parameter  int DEFAULT_DIV = c_default_div,
    localparam int SEL_W       = sel_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    // One extra bit so NUM_CH itself is representable when it is a power of 2
    localparam logic [SEL_W:0] c_num_ch = (SEL_W + 1)'(NUM_CH);

    logic       w_sel_ok;
    logic       w_val_ok;
    logic       w_accept;
    logic [1:0] w_resp_nxt;
    logic [1:0] r_resp;

    assign w_sel_ok = ({1'b0, div_sel} < c_num_ch);
    assign w_val_ok = (div_val != '0);
    assign w_accept = div_wr & w_sel_ok & w_val_ok;

    always_comb begin
        w_resp_nxt = c_resp_none;
        if (div_wr) begin
            w_resp_nxt = w_accept ? c_resp_ack : c_resp_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp <= c_resp_none;
        end else begin
            r_resp <= w_resp_nxt;
        end
    end

    assign div_ack = (r_resp == c_resp_ack);
    assign div_err = (r_resp == c_resp_err);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        logic w_ld;

        assign w_ld = w_accept && ({1'b0, div_sel} == (SEL_W + 1)'(gi));

        clkdiv_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[gi]),
            .ld      (w_ld),
            .ld_val  (div_val),
            .clk_div (clk_div[gi]),
            .tick    (tick[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_bank.sv
// ============================================================================
// Module      : tb_clkdiv_bank
// Description : Scoreboard bench for clkdiv_bank: expected write responses and
//               tick intervals are queued by stimulus and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clkdiv_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam logic [1:0] ACK = 2'b01;   // {err, ack}
    localparam logic [1:0] ERR = 2'b10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              div_wr;
    logic [1:0]        div_sel;
    logic [CNT_W-1:0]  div_val;
    logic              div_ack;
    logic              div_err;
    logic [NUM_CH-1:0] clk_div;
    logic [NUM_CH-1:0] tick;

    logic [2:0]        en3;
    logic              div_wr3;
    logic [1:0]        div_sel3;
    logic [CNT_W-1:0]  div_val3;
    logic              div_ack3;
    logic              div_err3;
    logic [2:0]        clk_div3;
    logic [2:0]        tick3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [1:0]        resp_q[$];
    logic [1:0]        resp3_q[$];
    int                ivq[NUM_CH][$];
    int                last_t[NUM_CH];
    logic [NUM_CH-1:0] act_q;
    logic [NUM_CH-1:0] div_q;
    logic              rst_q;
    logic              hold;

    clkdiv_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(500)) u_dut (
        .clk(clk), .rst(rst), .en(en), .div_wr(div_wr), .div_sel(div_sel),
        .div_val(div_val), .div_ack(div_ack), .div_err(div_err),
        .clk_div(clk_div), .tick(tick)
    );

    clkdiv_bank #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(500)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .div_wr(div_wr3), .div_sel(div_sel3),
        .div_val(div_val3), .div_ack(div_ack3), .div_err(div_err3),
        .clk_div(clk_div3), .tick(tick3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 200000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [NUM_CH-1:0] act;
        forever begin
            @(negedge clk);
            act = rst ? '0 : en;
            if (div_ack || div_err) begin
                if (resp_q.size() == 0) check("resp_unexpected", int'({div_err, div_ack}), 0);
                else check("resp", int'({div_err, div_ack}), int'(resp_q.pop_front()));
            end
            if (div_ack3 || div_err3) begin
                if (resp3_q.size() == 0) check("resp3_unexpected", int'({div_err3, div_ack3}), 0);
                else check("resp3", int'({div_err3, div_ack3}), int'(resp3_q.pop_front()));
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (rst_q) begin
                    check($sformatf("reset_out_ch%0d", i), int'({clk_div[i], tick[i]}), 0);
                end else begin
                    check($sformatf("toggle_vs_tick_ch%0d", i), int'(clk_div[i] ^ div_q[i]), int'(tick[i]));
                    if (!act_q[i]) check($sformatf("tick_stopped_ch%0d", i), int'(tick[i]), 0);
                    if (tick[i]) begin
                        if (ivq[i].size() > 0)
                            check($sformatf("interval_ch%0d", i), cyc - last_t[i], ivq[i].pop_front());
                        last_t[i] = cyc;
                    end
                end
                if (act[i] && !act_q[i]) last_t[i] = cyc;
            end
            act_q = act;
            div_q = clk_div;
            rst_q = rst;
        end
    endtask

    task automatic wait_tick(input int ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[ch] && n < 3000);
        if (!tick[ch]) check($sformatf("timeout_tick_ch%0d", ch), int'(tick[ch]), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit on3, input int sel, input int val, input logic [1:0] exp);
        if (on3) begin
            resp3_q.push_back(exp);
            div_wr3 = 1'b1; div_sel3 = 2'(sel); div_val3 = CNT_W'(val);
        end else begin
            resp_q.push_back(exp);
            div_wr = 1'b1; div_sel = 2'(sel); div_val = CNT_W'(val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_idle();
        div_wr  = 1'b0;
        div_wr3 = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = '0; div_wr = 1'b0; div_sel = '0; div_val = '0;
        en3 = '0; div_wr3 = 1'b0; div_sel3 = '0; div_val3 = '0;
        rst_q = 1'b1; act_q = '0; div_q = '0; hold = 1'b0;
        for (int i = 0; i < NUM_CH; i++) last_t[i] = 0;
        fork
            monitor();
        join_none

        // Reset defaults, ch0 at DEFAULT_DIV
        step(2);
        check("reset_clk_div", int'(clk_div), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_resp", int'({div_err, div_ack}), 0);
        ivq[0].push_back(500); ivq[0].push_back(500);
        rst = 1'b0; en = 4'b0001;
        wait_tick(0);
        check("ch0_level_1st", int'(clk_div[0]), 1);
        wait_tick(0);
        check("ch0_level_2nd", int'(clk_div[0]), 0);
        check("idle_clk_div", int'(clk_div[3:1]), 0);

        // Program ch2 to 3 mid half-period
        ivq[2].push_back(500);
        for (int k = 0; k < 3; k++) ivq[2].push_back(3);
        en[2] = 1'b1;
        step(10);
        wr(0, 2, 3, ACK); wr_idle();
        repeat (4) wait_tick(2);

        // Held write strobe: 7 then 5, only 5 is applied
        ivq[1].push_back(500);
        for (int k = 0; k < 3; k++) ivq[1].push_back(5);
        en[1] = 1'b1;
        step(10);
        wr(0, 1, 7, ACK); wr(0, 1, 5, ACK); wr_idle();
        repeat (4) wait_tick(1);

        // Rejected writes leave the divisor alone
        wr(0, 1, 0, ERR); wr_idle();
        ivq[1].push_back(5); ivq[1].push_back(5);
        repeat (2) wait_tick(1);
        wr(1, 3, 4, ERR); wr_idle();
        wr(1, 2, 4, ACK); wr_idle();
        wr(1, 0, 0, ERR); wr_idle();

        // Enable pause on ch0 at cnt=2
        wr(0, 0, 4, ACK); wr_idle();
        wait_tick(0);
        ivq[0].push_back(4);
        wait_tick(0);
        step(1);
        en[0] = 1'b0;
        hold = clk_div[0];
        step(10);
        check("ch0_frozen", int'(clk_div[0]), int'(hold));
        check("ch0_paused_tick", int'(tick[0]), 0);
        ivq[0].push_back(2); ivq[0].push_back(4);
        en[0] = 1'b1;
        wait_tick(0);
        wait_tick(0);

        // Reset with a pending write on ch3
        en[3] = 1'b1;
        step(5);
        wr(0, 3, 9, ACK); wr_idle();
        step(1);
        rst = 1'b1;
        ivq[3].push_back(500); ivq[3].push_back(500);
        step(2);
        check("rst_mid_clk_div", int'(clk_div), 0);
        rst = 1'b0;
        wait_tick(3);
        wait_tick(3);

        // div=1: toggle every cycle, tick held high
        wr(0, 3, 1, ACK); wr_idle();
        wait_tick(3);
        for (int k = 0; k < 6; k++) ivq[3].push_back(1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("div1_tick_high", int'(tick[3]), 1);
        end
        step(3);

        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("ivq_drained_ch%0d", i), ivq[i].size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        check("resp3_q_drained", resp3_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
